// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces the pixel tick, H/V counters, sync, blanking and client pixel coordinates
// from a single system clock. The client colour returns PIXEL_LATENCY ticks after its
// request, so the sync/blank decode travels through a matching delay line to stay aligned.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned H_DISPLAY     = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_DISPLAY     = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter bit          SYNC_POL      = 1'b0,
  parameter int unsigned RW            = 3,
  parameter int unsigned GW            = 3,
  parameter int unsigned BW            = 2,
  parameter int unsigned PIXEL_LATENCY = 0,
  localparam int unsigned CW = RW + GW + BW,
  localparam int unsigned XW = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1,
  localparam int unsigned YW = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1
) (
  input  logic          clk_50MHz,
  input  logic          RESET,
  input  logic          TEST_PATTERN,
  input  logic [CW-1:0] COLOR,
  output logic [XW-1:0] CURX,
  output logic [YW-1:0] CURY,
  output logic          REQ,
  output logic          PIX_CE,
  output logic          FRAME_START,
  output logic          hs_vga,
  output logic          vs_vga,
  output logic [RW-1:0] RED,
  output logic [GW-1:0] GREEN,
  output logic [BW-1:0] BLUE
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Width of one colour bar; the last bar absorbs any remainder by saturating.
  localparam int unsigned BAR_W    = (H_DISPLAY >= 8) ? (H_DISPLAY / 8) : 1;
  localparam int unsigned SW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned HS_START = H_DISPLAY + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(BAR_W - 1);

  logic [DW-1:0] d_q, d_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [2:0]    bar_q, bar_d;
  logic          pix_ce;
  logic          act, hs_raw, vs_raw;
  // Pipeline entry: {hs, vs, act, bar[2:0]}; all-zero is an inactive blanked pixel.
  logic [5:0]    stage0, tail;

  logic          hs_q, vs_q;
  logic [RW-1:0] red_q, red_d;
  logic [GW-1:0] green_q, green_d;
  logic [BW-1:0] blue_q, blue_d;

  // With CLK_DIV=1 the divider stays at 0 and the tick is permanently high.
  assign pix_ce = (d_q == D_LAST);

  // Next-state for divider, raster counters and colour-bar counter
  always_comb begin
    d_d   = pix_ce ? '0 : d_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    seg_d = seg_q;
    bar_d = bar_q;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d   = '0;
        v_d   = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        seg_d = '0;
        bar_d = '0;
      end else begin
        h_d = h_q + 1'b1;
        if (seg_q == S_LAST) begin
          seg_d = '0;
          if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
    end
  end

  // Counter state; reset wins over the pixel tick
  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      d_q   <= '0;
      h_q   <= '0;
      v_q   <= '0;
      seg_q <= '0;
      bar_q <= '0;
    end else begin
      d_q   <= d_d;
      h_q   <= h_d;
      v_q   <= v_d;
      seg_q <= seg_d;
      bar_q <= bar_d;
    end
  end

  // Stage-0 decode of the current raster position
  always_comb begin
    act    = (32'(h_q) < H_DISPLAY) && (32'(v_q) < V_DISPLAY);
    hs_raw = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    vs_raw = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
    stage0 = {hs_raw, vs_raw, act, bar_q};
  end

  assign REQ         = act;
  assign CURX        = act ? h_q[XW-1:0] : '0;
  assign CURY        = act ? v_q[YW-1:0] : '0;
  assign PIX_CE      = pix_ce;
  assign FRAME_START = pix_ce && (h_q == H_LAST) && (v_q == V_LAST);

  if (PIXEL_LATENCY == 0) begin : g_no_delay
    assign tail = stage0;
  end else begin : g_delay
    logic [5:0] dly_q [PIXEL_LATENCY];

    // Delay line matching the client colour latency, advanced on each pixel tick
    always_ff @(posedge clk_50MHz) begin
      if (RESET) begin
        for (int i = 0; i < int'(PIXEL_LATENCY); i++) dly_q[i] <= '0;
      end else if (pix_ce) begin
        dly_q[0] <= stage0;
        for (int i = 1; i < int'(PIXEL_LATENCY); i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign tail = dly_q[PIXEL_LATENCY-1];
  end

  // Colour selection for the pixel leaving the delay line
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (tail[3]) begin
      if (TEST_PATTERN) begin
        red_d   = {RW{tail[2]}};
        green_d = {GW{tail[1]}};
        blue_d  = {BW{tail[0]}};
      end else begin
        red_d   = COLOR[CW-1 -: RW];
        green_d = COLOR[BW +: GW];
        blue_d  = COLOR[BW-1:0];
      end
    end
  end

  // Output register: sync and colour update together on the pixel tick
  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pix_ce) begin
      hs_q    <= tail[5];
      vs_q    <= tail[4];
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign hs_vga = SYNC_POL ? hs_q : ~hs_q;
  assign vs_vga = SYNC_POL ? vs_q : ~vs_q;
  assign RED    = red_q;
  assign GREEN  = green_q;
  assign BLUE   = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small configurations sharing one clock.
// dut_a: CLK_DIV=1, 8x4 display, H_TOTAL=12, V_TOTAL=7, active-high sync, no latency.
// dut_b: CLK_DIV=2, 16x4 display, H_TOTAL=23, V_TOTAL=8, active-low sync, latency 2.
module tb_vga_timing_gen;
  logic       clk;

  logic       rst_a, tp_a;
  logic [7:0] col_a;
  logic [2:0] curx_a;
  logic [1:0] cury_a;
  logic       req_a, ce_a, fs_a, hs_a, vs_a;
  logic [2:0] red_a, green_a;
  logic [1:0] blue_a;

  logic       rst_b, tp_b;
  logic [7:0] col_b;
  logic [3:0] curx_b;
  logic [1:0] cury_b;
  logic       req_b, ce_b, fs_b, hs_b, vs_b;
  logic [2:0] red_b, green_b;
  logic [1:0] blue_b;

  logic [7:0] hist0, hist1;
  int         checks, failures;

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1),
    .RW(3), .GW(3), .BW(2), .PIXEL_LATENCY(0)
  ) dut_a (
    .clk_50MHz(clk), .RESET(rst_a), .TEST_PATTERN(tp_a), .COLOR(col_a),
    .CURX(curx_a), .CURY(cury_a), .REQ(req_a), .PIX_CE(ce_a), .FRAME_START(fs_a),
    .hs_vga(hs_a), .vs_vga(vs_a), .RED(red_a), .GREEN(green_a), .BLUE(blue_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0),
    .RW(3), .GW(3), .BW(2), .PIXEL_LATENCY(2)
  ) dut_b (
    .clk_50MHz(clk), .RESET(rst_b), .TEST_PATTERN(tp_b), .COLOR(col_b),
    .CURX(curx_b), .CURY(cury_b), .REQ(req_b), .PIX_CE(ce_b), .FRAME_START(fs_b),
    .hs_vga(hs_b), .vs_vga(vs_b), .RED(red_b), .GREEN(green_b), .BLUE(blue_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Client model for dut_b: answers each request with COLOR = CURX two ticks later.
  initial begin
    hist0 = 8'h00;
    hist1 = 8'h00;
    col_b = 8'h00;
    forever begin
      @(negedge clk);
      if (ce_b === 1'b1) begin
        col_b = hist1;
        hist1 = hist0;
        hist0 = {4'd0, curx_b};
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({hs_a, vs_a, red_a, green_a, blue_a} !== 10'd0) begin
      failures++;
      $display("FAIL reset_pins_a got=%b exp=%b", {hs_a, vs_a, red_a, green_a, blue_a}, 10'd0);
    end
    checks++;
    if ({req_a, curx_a, cury_a, fs_a, ce_a} !== 8'b1_000_00_0_1) begin
      failures++;
      $display("FAIL reset_ctl_a got=%b exp=%b", {req_a, curx_a, cury_a, fs_a, ce_a},
               8'b1_000_00_0_1);
    end
    checks++;
    if ({hs_b, vs_b, red_b, green_b, blue_b} !== 10'b11_00000000) begin
      failures++;
      $display("FAIL reset_pins_b got=%b exp=%b", {hs_b, vs_b, red_b, green_b, blue_b},
               10'b11_00000000);
    end
    checks++;
    if ({req_b, curx_b, cury_b, fs_b, ce_b} !== 9'b1_0000_00_0_0) begin
      failures++;
      $display("FAIL reset_ctl_b got=%b exp=%b", {req_b, curx_b, cury_b, fs_b, ce_b},
               9'b1_0000_00_0_0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if (ce_b !== 1'b1) begin
      failures++;
      $display("FAIL first_pix_ce_b got=%b exp=1", ce_b);
    end
  endtask

  // dut_a, two frames of passthrough colour with varying COLOR every tick.
  task automatic test_small_frame();
    int h, v, p, ph, pv, nfs;
    logic act0, exp_hs, exp_vs;
    logic [7:0] exp_rgb, col_prev;
    nfs = 0;
    tp_a = 1'b0;
    col_a = 8'h00;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    col_prev = col_a;
    for (int n = 0; n < 168; n++) begin
      h = n % 12;
      v = (n / 12) % 7;
      act0 = (h < 8) && (v < 4);
      p = n - 1;
      if (p < 0) begin
        exp_hs = 1'b0; exp_vs = 1'b0; exp_rgb = 8'h00;
      end else begin
        ph = p % 12;
        pv = (p / 12) % 7;
        exp_hs = (ph >= 9) && (ph < 11);
        exp_vs = (pv == 5);
        exp_rgb = ((ph < 8) && (pv < 4)) ? col_prev : 8'h00;
      end
      checks++;
      if ({hs_a, vs_a} !== {exp_hs, exp_vs}) begin
        failures++;
        $display("FAIL sync_a n=%0d got=%b exp=%b", n, {hs_a, vs_a}, {exp_hs, exp_vs});
      end
      checks++;
      if ({red_a, green_a, blue_a} !== exp_rgb) begin
        failures++;
        $display("FAIL color_a n=%0d got=%h exp=%h", n, {red_a, green_a, blue_a}, exp_rgb);
      end
      checks++;
      if ({req_a, curx_a, cury_a} !== {act0, act0 ? 3'(h) : 3'd0, act0 ? 2'(v) : 2'd0}) begin
        failures++;
        $display("FAIL coord_a n=%0d got=%b exp=%b", n, {req_a, curx_a, cury_a},
                 {act0, act0 ? 3'(h) : 3'd0, act0 ? 2'(v) : 2'd0});
      end
      checks++;
      if ({fs_a, ce_a} !== {(h == 11) && (v == 6), 1'b1}) begin
        failures++;
        $display("FAIL frame_start_a n=%0d got=%b exp=%b", n, {fs_a, ce_a},
                 {(h == 11) && (v == 6), 1'b1});
      end
      if (fs_a === 1'b1) nfs++;
      col_a = 8'(n * 29 + 7);
      col_prev = col_a;
      @(negedge clk);
    end
    checks++;
    if (nfs != 2) begin
      failures++;
      $display("FAIL frame_count_a got=%0d exp=2", nfs);
    end
  endtask

  // dut_a, TEST_PATTERN toggled every five ticks; bars are one pixel wide here.
  task automatic test_pattern_toggle();
    int p, ph, pv;
    logic tp_prev, exp_hs;
    logic [2:0] b3;
    logic [7:0] exp_rgb;
    tp_a = 1'b0;
    col_a = 8'h5A;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    tp_prev = tp_a;
    for (int n = 0; n < 84; n++) begin
      p = n - 1;
      exp_rgb = 8'h00;
      exp_hs = 1'b0;
      if (p >= 0) begin
        ph = p % 12;
        pv = (p / 12) % 7;
        b3 = 3'(ph);
        exp_hs = (ph >= 9) && (ph < 11);
        if ((ph < 8) && (pv < 4))
          exp_rgb = tp_prev ? {{3{b3[2]}}, {3{b3[1]}}, {2{b3[0]}}} : 8'h5A;
      end
      checks++;
      if ({red_a, green_a, blue_a} !== exp_rgb) begin
        failures++;
        $display("FAIL toggle_color_a n=%0d got=%h exp=%h", n, {red_a, green_a, blue_a},
                 exp_rgb);
      end
      checks++;
      if (hs_a !== exp_hs) begin
        failures++;
        $display("FAIL toggle_sync_a n=%0d got=%b exp=%b", n, hs_a, exp_hs);
      end
      tp_a = ((n / 5) % 2) == 0;
      tp_prev = tp_a;
      @(negedge clk);
    end
    tp_a = 1'b0;
  endtask

  // dut_b, two frames with the latency-2 client; pins trail requests by three ticks.
  task automatic test_latency_passthrough();
    int t, h, v, p, ph, pv;
    logic act0, exp_hs, exp_vs, exp_fs;
    logic [7:0] exp_rgb;
    tp_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int n = 0; n < 736; n++) begin
      t = n / 2;
      h = t % 23;
      v = (t / 23) % 8;
      act0 = (h < 16) && (v < 4);
      p = t - 3;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 8'h00;
      if (p >= 0) begin
        ph = p % 23;
        pv = (p / 23) % 8;
        exp_hs = !((ph >= 18) && (ph < 21));
        exp_vs = !((pv >= 5) && (pv < 7));
        if ((ph < 16) && (pv < 4)) exp_rgb = 8'(ph);
      end
      exp_fs = (n % 2 == 1) && (h == 22) && (v == 7);
      checks++;
      if ({hs_b, vs_b} !== {exp_hs, exp_vs}) begin
        failures++;
        $display("FAIL sync_b n=%0d got=%b exp=%b", n, {hs_b, vs_b}, {exp_hs, exp_vs});
      end
      checks++;
      if ({red_b, green_b, blue_b} !== exp_rgb) begin
        failures++;
        $display("FAIL color_b n=%0d got=%h exp=%h", n, {red_b, green_b, blue_b}, exp_rgb);
      end
      checks++;
      if ({req_b, curx_b, cury_b} !== {act0, act0 ? 4'(h) : 4'd0, act0 ? 2'(v) : 2'd0}) begin
        failures++;
        $display("FAIL coord_b n=%0d got=%b exp=%b", n, {req_b, curx_b, cury_b},
                 {act0, act0 ? 4'(h) : 4'd0, act0 ? 2'(v) : 2'd0});
      end
      checks++;
      if ({fs_b, ce_b} !== {exp_fs, n % 2 == 1}) begin
        failures++;
        $display("FAIL tick_b n=%0d got=%b exp=%b", n, {fs_b, ce_b}, {exp_fs, n % 2 == 1});
      end
      @(negedge clk);
    end
  endtask

  // dut_b, colour bars two pixels wide with COLOR ignored.
  task automatic test_pattern_bars();
    int t, p, ph, pv;
    logic [2:0] b3;
    logic [7:0] exp_rgb;
    tp_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int n = 0; n < 368; n++) begin
      t = n / 2;
      p = t - 3;
      exp_rgb = 8'h00;
      if (p >= 0) begin
        ph = p % 23;
        pv = (p / 23) % 8;
        b3 = 3'(ph / 2);
        if ((ph < 16) && (pv < 4)) exp_rgb = {{3{b3[2]}}, {3{b3[1]}}, {2{b3[0]}}};
      end
      checks++;
      if ({red_b, green_b, blue_b} !== exp_rgb) begin
        failures++;
        $display("FAIL bars_b n=%0d got=%h exp=%h", n, {red_b, green_b, blue_b}, exp_rgb);
      end
      @(negedge clk);
    end
  endtask

  // dut_b, RESET held five clocks mid-line, then restart.
  task automatic test_reset_midline();
    tp_b = 1'b0;
    repeat (37) @(negedge clk);
    rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({hs_b, vs_b, red_b, green_b, blue_b} !== 10'b11_00000000) begin
        failures++;
        $display("FAIL midreset_pins_b k=%0d got=%b exp=%b", k,
                 {hs_b, vs_b, red_b, green_b, blue_b}, 10'b11_00000000);
      end
      checks++;
      if ({req_b, curx_b, cury_b, fs_b, ce_b} !== 9'b1_0000_00_0_0) begin
        failures++;
        $display("FAIL midreset_ctl_b k=%0d got=%b exp=%b", k,
                 {req_b, curx_b, cury_b, fs_b, ce_b}, 9'b1_0000_00_0_0);
      end
    end
    rst_b = 1'b0;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if ({ce_b, req_b, curx_b, cury_b} !== {n % 2 == 1, 1'b1, 4'(n / 2), 2'd0}) begin
        failures++;
        $display("FAIL restart_b n=%0d got=%b exp=%b", n, {ce_b, req_b, curx_b, cury_b},
                 {n % 2 == 1, 1'b1, 4'(n / 2), 2'd0});
      end
      checks++;
      if ({hs_b, vs_b, red_b, green_b, blue_b} !== 10'b11_00000000) begin
        failures++;
        $display("FAIL restart_pins_b n=%0d got=%b exp=%b", n,
                 {hs_b, vs_b, red_b, green_b, blue_b}, 10'b11_00000000);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tp_a = 1'b0;
    tp_b = 1'b0;
    col_a = 8'h00;
    test_reset();
    test_small_frame();
    test_pattern_toggle();
    test_latency_passthrough();
    test_pattern_bars();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
